// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: configuration-chain sequencer for one scan chain of CHAIN_LEN flops.
// Takes configuration words from a host over valid/ready and shifts them LSB-first into
// ccff_head while gating the chain with ccff_clk_en. The old chain contents, sampled from
// ccff_tail on the same shifting edges, come back as packed readback words.
//
// Ports:
//   prog_clk / prog_reset  configuration clock (rising edge) and async active-low reset
//   start / abort          begin a load (sampled only in IDLE) / cancel the running load
//   cfg_data/valid/ready   host word handshake; bit 0 of each word is shifted first
//   ccff_head/ccff_tail    serial data into / out of the chain
//   ccff_clk_en            chain shifts on the edge closing a cycle where this is 1
//   rb_data / rb_valid     readback word, right-aligned, with a one-cycle valid pulse
//   busy / done            non-IDLE indicator / one-cycle completion pulse
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_clk_en,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StWait, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  total_q, total_d;    // bits shifted so far in this load
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;      // bits still to shift from the current word
  logic [CNT_W-1:0]  wlen_q, wlen_d;      // bit count of the current word
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WORD_W-1:0] rbsh_q, rbsh_d;      // readback capture, filled from the top
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  int unsigned       remain;
  int unsigned       take;
  logic [WORD_W-1:0] rb_next;

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    wcnt_d     = wcnt_q;
    wlen_d     = wlen_q;
    sreg_d     = sreg_q;
    rbsh_d     = rbsh_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;

    remain  = CHAIN_LEN - 32'(total_q);
    take    = (remain < WORD_W) ? remain : WORD_W;
    // Old tail bit enters at the top; after a full word the first captured bit is in bit 0.
    rb_next = (rbsh_q >> 1) | (WORD_W'(ccff_tail) << (WORD_W - 1));

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          total_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cfg_valid) begin
          sreg_d  = cfg_data;
          wcnt_d  = take[CNT_W-1:0];
          wlen_d  = take[CNT_W-1:0];
          rbsh_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        sreg_d  = sreg_q >> 1;
        rbsh_d  = rb_next;
        total_d = total_q + CNT_W'(1);
        wcnt_d  = wcnt_q - CNT_W'(1);
        if (wcnt_q == CNT_W'(1)) begin
          rb_valid_d = 1'b1;
          // A short last word sits in the top bits; move it down to bit 0.
          rb_data_d  = rb_next >> (WORD_W - 32'(wlen_q));
          state_d    = (total_q == CNT_W'(CHAIN_LEN - 1)) ? StDone : StWait;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      rb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q    <= StIdle;
      total_q    <= '0;
      wcnt_q     <= '0;
      wlen_q     <= '0;
      sreg_q     <= '0;
      rbsh_q     <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      wcnt_q     <= wcnt_d;
      wlen_q     <= wlen_d;
      sreg_q     <= sreg_d;
      rbsh_q     <= rbsh_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  // All outputs decode registered state only.
  assign cfg_ready   = (state_q == StWait);
  assign ccff_clk_en = (state_q == StShift);
  assign ccff_head   = ccff_clk_en & sreg_q[0];
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign rb_data     = rb_data_q;
  assign rb_valid    = rb_valid_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 16-flop/8-bit instance and a 12-flop/8-bit instance, each
// driving a simple behavioural chain. Expected head bits, readback words and latency come
// from the image being loaded and from the chain contents before the load.
module tb_ccff_chain_loader;

  logic        clk        = 1'b0;
  logic        prog_reset = 1'b0;
  logic [1:0]  start      = '0;
  logic [1:0]  abort      = '0;
  logic [1:0]  cfg_valid  = '0;
  logic [7:0]  cfg_data [2];
  logic [1:0]  cfg_ready, head, tail, clk_en, rb_valid, busy, done;
  logic [7:0]  rb_data [2];
  logic [15:0] chain0 = '0;
  logic [11:0] chain1 = '0;

  int          n_vec    = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic        head_q [$];
  logic [7:0]  rb_q [$];

  typedef struct {
    logic [15:0] img;
    int          gap;
    int          restart_at;
    int          exp_lat;
    logic [15:0] exp_rb;
  } vec_t;

  always #5 clk = ~clk;

  assign tail[0] = chain0[0];
  assign tail[1] = chain1[0];

  ccff_chain_loader u_dut16 (
    .prog_clk   (clk),
    .prog_reset (prog_reset),
    .start      (start[0]),
    .abort      (abort[0]),
    .cfg_data   (cfg_data[0]),
    .cfg_valid  (cfg_valid[0]),
    .cfg_ready  (cfg_ready[0]),
    .ccff_head  (head[0]),
    .ccff_tail  (tail[0]),
    .ccff_clk_en(clk_en[0]),
    .rb_data    (rb_data[0]),
    .rb_valid   (rb_valid[0]),
    .busy       (busy[0]),
    .done       (done[0])
  );

  ccff_chain_loader #(
    .CHAIN_LEN(12),
    .WORD_W   (8)
  ) u_dut12 (
    .prog_clk   (clk),
    .prog_reset (prog_reset),
    .start      (start[1]),
    .abort      (abort[1]),
    .cfg_data   (cfg_data[1]),
    .cfg_valid  (cfg_valid[1]),
    .cfg_ready  (cfg_ready[1]),
    .ccff_head  (head[1]),
    .ccff_tail  (tail[1]),
    .ccff_clk_en(clk_en[1]),
    .rb_data    (rb_data[1]),
    .rb_valid   (rb_valid[1]),
    .busy       (busy[1]),
    .done       (done[1])
  );

  // Behavioural chains: index 0 is the flop nearest ccff_tail.
  always @(posedge clk) begin
    if (clk_en[0]) chain0 <= {head[0], chain0[15:1]};
    if (clk_en[1]) chain1 <= {head[1], chain1[11:1]};
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Only one instance is ever active, so one set of queues serves both.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (clk_en[s]) head_q.push_back(head[s]);
      else chk("head_when_idle", 32'(head[s]), 32'd0);
      if (rb_valid[s]) rb_q.push_back(rb_data[s]);
      if (done[s]) done_cnt++;
    end
  end

  task automatic run_load(input int s, input logic [15:0] img, input int gap,
                          input int restart_at, input int exp_lat, input logic [15:0] exp_rb);
    int          len, nw, widx, hold, cyc, done_at;
    logic        hs;
    logic [15:0] mask;
    len     = (s == 0) ? 16 : 12;
    mask    = (s == 0) ? 16'hFFFF : 16'h0FFF;
    nw      = (len + 7) / 8;
    head_q.delete();
    rb_q.delete();
    done_cnt = 0;
    widx     = 0;
    hold     = 0;
    done_at  = -1;
    start[s] = 1'b1;
    @(negedge clk);
    cyc = 1;
    start[s] = 1'b0;
    while (done_at < 0 && cyc < 200) begin
      start[s] = 1'(cyc == restart_at);
      if (widx == 1 && hold < gap) begin
        cfg_valid[s] = 1'b0;
        if (cfg_ready[s]) begin
          hold++;
          chk("backpressure_clk_en", 32'(clk_en[s]), 32'd0);
        end
      end else begin
        cfg_valid[s] = 1'(widx < nw);
        if (widx < nw) cfg_data[s] = img[widx*8 +: 8];
      end
      hs = cfg_valid[s] & cfg_ready[s];
      @(negedge clk);
      cyc++;
      if (hs) widx++;
      if (done[s]) done_at = cyc;
    end
    start[s]     = 1'b0;
    cfg_valid[s] = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_after_done", 32'(busy[s]), 32'd0);
    chk("done_latency", done_at, exp_lat);
    chk("done_pulses", done_cnt, 1);
    chk("shift_cycles", head_q.size(), len);
    for (int i = 0; i < len; i++)
      if (i < head_q.size()) chk("head_bit", 32'(head_q[i]), 32'(img[i]));
    chk("rb_pulses", rb_q.size(), nw);
    for (int w = 0; w < nw; w++)
      if (w < rb_q.size()) chk("rb_word", 32'(rb_q[w]), 32'(exp_rb[w*8 +: 8]));
    chk("chain_image", (s == 0) ? 32'(chain0) : 32'(chain1), 32'(img & mask));
  endtask

  initial begin
    vec_t        vecs [4];
    logic [15:0] img;
    int          gap, rs;

    cfg_data[0] = '0;
    cfg_data[1] = '0;
    vecs[0] = '{img: 16'h3CA5, gap: 0, restart_at: 0, exp_lat: 19, exp_rb: 16'h0000};
    vecs[1] = '{img: 16'h00FF, gap: 0, restart_at: 0, exp_lat: 19, exp_rb: 16'h3CA5};
    vecs[2] = '{img: 16'h5A96, gap: 5, restart_at: 0, exp_lat: 24, exp_rb: 16'h00FF};
    vecs[3] = '{img: 16'hC3E1, gap: 0, restart_at: 6, exp_lat: 19, exp_rb: 16'h5A96};

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({cfg_ready, head, clk_en, rb_valid, busy, done}), 32'd0);
    prog_reset = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_outputs", 32'({cfg_ready, head, clk_en, rb_valid, busy, done}), 32'd0);
    chk("post_reset_rb", 32'({rb_data[0], rb_data[1]}), 32'd0);

    // Done arrives 20 cycles after start counting both ends: offset 19 (+ stall cycles).
    for (int v = 0; v < 4; v++)
      run_load(0, vecs[v].img, vecs[v].gap, vecs[v].restart_at, vecs[v].exp_lat, vecs[v].exp_rb);

    // Abort and start together in IDLE: stays idle.
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    chk("abort_beats_start", 32'({busy[0], cfg_ready[0]}), 32'd0);

    // Abort on shift bit 3.
    #1;
    head_q.delete();
    rb_q.delete();
    done_cnt     = 0;
    start[0]     = 1'b1;
    cfg_valid[0] = 1'b1;
    cfg_data[0]  = 8'h5A;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_at_bit3_shifting", 32'(clk_en[0]), 32'd1);
    abort[0]     = 1'b1;
    cfg_valid[0] = 1'b0;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_state", 32'({busy[0], clk_en[0], cfg_ready[0]}), 32'd0);
    repeat (20) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_rb", rb_q.size(), 0);
    chk("abort_bits_shifted", head_q.size(), 4);
    if (head_q.size() == 4)
      chk("abort_head_bits", 32'({head_q[3], head_q[2], head_q[1], head_q[0]}), 32'hA);

    // Random images, stalls and ignored restarts; readback expects the prior chain contents.
    for (int n = 0; n < 20; n++) begin
      img = 16'($urandom);
      gap = int'($urandom_range(0, 3));
      rs  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 17)) : 0;
      run_load(0, img, gap, rs, 19 + gap, chain0);
    end

    // 12-flop chain: second word is cut to 4 bits and read back right-aligned.
    run_load(1, 16'hF3FF, 0, 0, 15, 16'h0000);
    run_load(1, 16'h0000, 2, 0, 17, 16'h03FF);

    // Asynchronous reset on shift bit 5.
    start[0]     = 1'b1;
    cfg_valid[0] = 1'b1;
    cfg_data[0]  = 8'hC3;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("reset_at_bit5_shifting", 32'(clk_en[0]), 32'd1);
    #2;
    prog_reset = 1'b0;
    #1;
    chk("async_reset_outputs",
        32'({cfg_ready[0], head[0], clk_en[0], rb_valid[0], busy[0], done[0]}), 32'd0);
    chk("async_reset_rb", 32'(rb_data[0]), 32'd0);
    cfg_valid[0] = 1'b0;
    @(negedge clk);
    prog_reset = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_after_async_reset", 32'(busy[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain sequencer for the connection-block scan chain. It accepts configuration words from a host over a valid/ready handshake and serialises them into the chain's `ccff_head` input. It gates chain shifting through a clock-enable output and returns the chain's previous contents, captured from `ccff_tail`, as packed readback words. One instance drives one chain of `CHAIN_LEN` flops, such as the 4 × 4-bit tapbuf mux memories of a CBY tile.

## Interface
Parameters:
- `CHAIN_LEN`, 16, number of flops in the driven chain (≥1).
- `WORD_W`, 8, configuration/readback word width (≥1).
- `CNT_W`, clog2(CHAIN_LEN+1), derived width of the bit counter; not overridden.

Ports:
- `prog_clk` input 1: configuration clock, rising edge.
- `prog_reset` input 1: reset, asynchronous, active-low (0 = reset).
- `start` input 1: begin a load sequence; sampled only in IDLE.
- `abort` input 1: cancel the sequence in progress.
- `cfg_data` input WORD_W: configuration word; bit 0 is shifted first.
- `cfg_valid` input 1: `cfg_data` valid.
- `cfg_ready` output 1: block accepts `cfg_data` this cycle.
- `ccff_head` output 1: serial data into the chain.
- `ccff_tail` input 1: serial data out of the last chain flop.
- `ccff_clk_en` output 1: chain shift enable; the chain shifts on the edge that closes a cycle in which this is 1.
- `rb_data` output WORD_W: readback word.
- `rb_valid` output 1: one-cycle pulse when `rb_data` is updated.
- `busy` output 1: high in any non-IDLE state.
- `done` output 1: one-cycle pulse when all `CHAIN_LEN` bits have been shifted.

## Operation
- States:
  - IDLE: on `start`=1 and `abort`=0, clear the total bit count and go to WAIT.
  - WAIT: `cfg_ready`=1. On `cfg_valid`, load the shift register with `cfg_data` and set the word count to min(`WORD_W`, `CHAIN_LEN` − total). Go to SHIFT.
  - SHIFT: `ccff_clk_en`=1 and `ccff_head`=sreg[0]. Each cycle, shift sreg right, shift `ccff_tail` into the top of the readback register, increment total, decrement the word count.
    - When the word count reaches 0 and total = `CHAIN_LEN`, go to DONE.
    - When the word count reaches 0 and total < `CHAIN_LEN`, go to WAIT.
  - DONE: `done`=1, then IDLE.
- Bit ordering:
  - Bit 0 of the first word enters the chain first and ends in the flop nearest `ccff_tail`.
  - The bit order of the configuration image matches the chain order, tail to head.
- Partial last word: only the remaining bits are shifted; the upper `cfg_data` bits are ignored.
- Readback:
  - `ccff_tail` is sampled on the same edge that shifts the chain, so the pre-shift (old) tail bit is captured.
  - Bits are packed with the first captured bit in bit 0.
  - A partial last word is right-aligned with zeros above.
  - `rb_data` holds its value until the next `rb_valid` pulse. There is no readback backpressure.
- `abort`:
  - In any non-IDLE state, the next state is IDLE. `ccff_clk_en` is 0 from that edge on.
  - No `done` and no further `rb_valid` are produced. Chain contents are partially updated; the host must restart.
  - `abort` with `start` in IDLE: `abort` wins and the block stays IDLE.
- `start` while `busy` is ignored. `cfg_valid` outside WAIT is ignored (`cfg_ready`=0).
- `cfg_data` changes while `cfg_valid`=1 and `cfg_ready`=0 are legal and ignored.

## Timing
- All outputs are registered or decoded from registered state. No combinational path exists from any input to any output.
- Reset values: `cfg_ready`=0, `ccff_head`=0, `ccff_clk_en`=0, `rb_data`=0, `rb_valid`=0, `busy`=0, `done`=0, state IDLE.
- Assertion of `prog_reset`=0 forces all outputs to their reset values immediately, including mid-SHIFT. Chain contents are then undefined.
- Latency with `cfg_valid` held high, where N = number of words = ceil(`CHAIN_LEN`/`WORD_W`):
  - `start` edge → WAIT (`cfg_ready`=1) on the next cycle.
  - Each word costs 1 WAIT cycle plus its bit count in SHIFT cycles.
  - `done` pulses on the cycle after the final shift cycle.
  - Total from the `start` cycle to the `done` cycle: 1 + N + `CHAIN_LEN` + 1 cycles. For the defaults this is 20.
- `rb_valid` pulses in the cycle after the last shift of each word, coincident with WAIT or DONE.
- `ccff_head` is valid in every cycle in which `ccff_clk_en`=1. It is 0 otherwise.

## Test plan
- Reset, defaults: drive `prog_reset`=0 for 3 cycles, then release → all outputs 0, `busy`=0.
- Full load, defaults: `start`, then words 0xA5 and 0x3C with `cfg_valid` held → `ccff_clk_en` high for exactly 16 cycles. The head sequence is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. `done` arrives 20 cycles after `start`.
- Readback: reload the chain with 0xFF, 0x00 after the previous test → `rb_data` = 0xA5 then 0x3C, each with a one-cycle `rb_valid`.
- Partial word, `CHAIN_LEN`=12, `WORD_W`=8: words 0xFF, 0xF3 → second word shifts only 4 bits (1,1,0,0). Second `rb_data` has upper 4 bits = 0.
- Backpressure: deassert `cfg_valid` for 5 cycles between words → block holds in WAIT with `ccff_clk_en`=0 and `cfg_ready`=1. It resumes with no lost or duplicated bits.
- Abort and mid-shift reset:
  - `abort` at shift bit 3 → IDLE next cycle, no `done`; a `start` pulse while `busy` has no effect.
  - Async reset at shift bit 5 → outputs clear before the next edge.
